move_arbiter: RTL and testbench
===============================

Name: move_arbiter

Overview:
- Shares the 10x6 tile grid between player A and player B.
- Accepts per-player single-cycle move requests decoded from the keyboard and serialises them through one evaluation path.
- For each move: enforces grid bounds and tile exclusivity (no two players on one tile) and a per-player move-rate cooldown.
- Owns both players' tile coordinates, which it drives to the pixel generator and seven-segment mux.

Parameters:
- HMAX, 9: largest horizontal tile index; minimum is 0.
- VMAX, 5: largest vertical tile index; minimum is 0.
- COOLDOWN, 25000000: cycles after a granted move before that player may request again; must be >= 1.
- AINIT_H, 0: A horizontal position at reset.
- AINIT_V, 0: A vertical position at reset.
- BINIT_H, 9: B horizontal position at reset.
- BINIT_V, 5: B vertical position at reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- a_req  in  1  A move request, single-cycle pulse
- a_dir  in  2  A direction: 00 up (v-1), 01 down (v+1), 10 left (h-1), 11 right (h+1)
- b_req  in  1  B move request, single-cycle pulse
- b_dir  in  2  B direction, same encoding as a_dir
- a_h  out  4  A horizontal tile
- a_v  out  4  A vertical tile
- b_h  out  4  B horizontal tile
- b_v  out  4  B vertical tile
- a_grant  out  1  pulse: A move committed
- b_grant  out  1  pulse: B move committed
- a_blocked  out  1  pulse: A move rejected
- b_blocked  out  1  pulse: B move rejected

Behaviour:
- Reset:
  - Positions load the INIT parameters.
  - All grant/blocked pulses 0, pending flags 0, cooldown counters 0.
  - State IDLE; last_served = B, so A wins the first tie.
- Request acceptance, per player:
  - req is sampled at the clock edge ending its cycle.
  - It is accepted only if that player's cooldown == 0 and the player is not currently selected in EVAL. Otherwise it is dropped silently.
  - An accepted req sets pending and captures dir.
  - A second accepted req while still pending overwrites dir; latest wins.
- FSM states: IDLE, EVAL.
  - IDLE: if no pending, stay. If one player is pending, select it. If both are pending, select the player != last_served. The selected player's pending clears and its dir moves to the eval register; go to EVAL.
  - EVAL (one cycle):
    - Compute the target tile.
    - Blocked if the target is outside [0,HMAX]x[0,VMAX]. Compare before decrementing so 0-1 never wraps.
    - Blocked if the target equals the other player's current position.
    - Else update the position.
    - At the next edge: grant or blocked pulses high for exactly one cycle; last_served = selected player; state returns to IDLE.
  - The non-selected player's pending is kept and served in the next IDLE cycle.
- Latency: req in cycle 0 -> pending in cycle 1 (IDLE selects) -> EVAL in cycle 2 -> new position and pulse visible in cycle 3. Back-to-back service of the second pending player commits at cycle 5.
- Cooldown:
  - On grant, the selected player's counter = COOLDOWN, visible in the commit cycle.
  - It decrements by 1 per cycle, saturating at 0.
  - Blocked moves do not load cooldown.
- Positions change only in EVAL commit; never both players in the same cycle.
- A and B pulses are never high together.
- rst asserted in any state, including EVAL, wins: full reset state next cycle, and the in-flight move is discarded with no pulse.
- Collision is checked against the other player's registered position, which already includes any move committed earlier.

Test Plan:
- Reset with default params -> a_h/a_v=0/0, b_h/b_v=9/5, all pulses 0, for at least 3 cycles with no req.
- a_req pulse, dir 11, at cycle 0 -> cycle 3: a_h=1, a_grant=1 for one cycle; cycles 1-2 position still 0.
- A at (0,0), a_req dir 00 -> a_blocked pulse at cycle 3, position unchanged; a new a_req at cycle 4 is accepted (no cooldown) and commits at cycle 7.
- a_req dir 11 and b_req dir 10 both in cycle 0 after reset:
  - cycle 3: a_h=1, a_grant.
  - cycle 5: b_h=8, b_grant.
  - No overlap of pulses.
- AINIT_H=8, AINIT_V=5; a_req dir 11 -> a_blocked at cycle 3 (tile 9,5 occupied by B), a_h stays 8.
- COOLDOWN=4; A granted at cycle 3:
  - a_req at cycle 5 is dropped, with no pulse through cycle 9.
  - a_req at cycle 7 (cooldown 0) commits at cycle 10.
  - rst at cycle 9 -> no pulse at cycle 10, positions back to INIT.

Source files
------------

// File: rtl/move_arbiter.sv
// Serialises player A/B tile moves through one evaluation path.
// Ports: clk, rst, {a,b}_req/_dir in; {a,b}_h/_v, _grant, _blocked out.
module move_arbiter #(
  parameter int HMAX     = 9,
  parameter int VMAX     = 5,
  parameter int COOLDOWN = 25000000,
  parameter int AINIT_H  = 0,
  parameter int AINIT_V  = 0,
  parameter int BINIT_H  = 9,
  parameter int BINIT_V  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic [1:0] a_dir,
  input  logic       b_req,
  input  logic [1:0] b_dir,
  output logic [3:0] a_h,
  output logic [3:0] a_v,
  output logic [3:0] b_h,
  output logic [3:0] b_v,
  output logic       a_grant,
  output logic       b_grant,
  output logic       a_blocked,
  output logic       b_blocked
);

  localparam int CW = $clog2(COOLDOWN + 1);
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN);
  localparam logic [3:0] HMAX_L = 4'(HMAX);
  localparam logic [3:0] VMAX_L = 4'(VMAX);

  typedef enum logic {IDLE, EVAL} state_t;

  // sel/last: 0 = player A, 1 = player B
  state_t          state_q, state_d;
  logic            sel_q, sel_d;
  logic            last_q, last_d;
  logic            a_pend_q, a_pend_d;
  logic            b_pend_q, b_pend_d;
  logic [1:0]      a_pdir_q, a_pdir_d;
  logic [1:0]      b_pdir_q, b_pdir_d;
  logic [1:0]      edir_q, edir_d;
  logic [3:0]      a_h_q, a_h_d, a_v_q, a_v_d;
  logic [3:0]      b_h_q, b_h_d, b_v_q, b_v_d;
  logic [CW-1:0]   a_cd_q, a_cd_d;
  logic [CW-1:0]   b_cd_q, b_cd_d;
  logic            a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic            a_blk_q, a_blk_d, b_blk_q, b_blk_d;

  logic       a_acc, b_acc, pick_b;
  logic [3:0] cur_h, cur_v, oth_h, oth_v;
  logic [3:0] tgt_h, tgt_v;
  logic       oob, blocked;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    a_pend_d = a_pend_q;
    b_pend_d = b_pend_q;
    a_pdir_d = a_pdir_q;
    b_pdir_d = b_pdir_q;
    edir_d   = edir_q;
    a_h_d    = a_h_q;
    a_v_d    = a_v_q;
    b_h_d    = b_h_q;
    b_v_d    = b_v_q;
    a_gnt_d  = 1'b0;
    b_gnt_d  = 1'b0;
    a_blk_d  = 1'b0;
    b_blk_d  = 1'b0;
    pick_b   = 1'b0;
    a_cd_d   = (a_cd_q != '0) ? a_cd_q - CW'(1) : '0;
    b_cd_d   = (b_cd_q != '0) ? b_cd_q - CW'(1) : '0;

    cur_h = sel_q ? b_h_q : a_h_q;
    cur_v = sel_q ? b_v_q : a_v_q;
    oth_h = sel_q ? a_h_q : b_h_q;
    oth_v = sel_q ? a_v_q : b_v_q;
    tgt_h = cur_h;
    tgt_v = cur_v;
    oob   = 1'b0;
    // bounds are tested before stepping so 0-1 never wraps
    unique case (edir_q)
      2'b00: if (cur_v == 4'd0) oob = 1'b1;
             else tgt_v = cur_v - 4'd1;
      2'b01: if (cur_v >= VMAX_L) oob = 1'b1;
             else tgt_v = cur_v + 4'd1;
      2'b10: if (cur_h == 4'd0) oob = 1'b1;
             else tgt_h = cur_h - 4'd1;
      2'b11: if (cur_h >= HMAX_L) oob = 1'b1;
             else tgt_h = cur_h + 4'd1;
    endcase
    blocked = oob || (tgt_h == oth_h && tgt_v == oth_v);

    unique case (state_q)
      IDLE: begin
        if (a_pend_q || b_pend_q) begin
          // on a tie, serve whoever was not served last
          pick_b = b_pend_q && (!a_pend_q || !last_q);
          sel_d  = pick_b;
          edir_d = pick_b ? b_pdir_q : a_pdir_q;
          if (pick_b) b_pend_d = 1'b0;
          else        a_pend_d = 1'b0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (blocked) begin
          a_blk_d = !sel_q;
          b_blk_d = sel_q;
        end else if (sel_q) begin
          b_h_d   = tgt_h;
          b_v_d   = tgt_v;
          b_gnt_d = 1'b1;
          b_cd_d  = CD_LOAD;
        end else begin
          a_h_d   = tgt_h;
          a_v_d   = tgt_v;
          a_gnt_d = 1'b1;
          a_cd_d  = CD_LOAD;
        end
        last_d  = sel_q;
        state_d = IDLE;
      end
    endcase

    // a fresh request outranks the pending-clear of selection
    a_acc = a_req && (a_cd_q == '0) &&
            !(state_q == EVAL && !sel_q);
    b_acc = b_req && (b_cd_q == '0) &&
            !(state_q == EVAL && sel_q);
    if (a_acc) begin
      a_pend_d = 1'b1;
      a_pdir_d = a_dir;
    end
    if (b_acc) begin
      b_pend_d = 1'b1;
      b_pdir_d = b_dir;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      a_pend_q <= 1'b0;
      b_pend_q <= 1'b0;
      a_pdir_q <= 2'b00;
      b_pdir_q <= 2'b00;
      edir_q   <= 2'b00;
      a_h_q    <= 4'(AINIT_H);
      a_v_q    <= 4'(AINIT_V);
      b_h_q    <= 4'(BINIT_H);
      b_v_q    <= 4'(BINIT_V);
      a_cd_q   <= '0;
      b_cd_q   <= '0;
      a_gnt_q  <= 1'b0;
      b_gnt_q  <= 1'b0;
      a_blk_q  <= 1'b0;
      b_blk_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      a_pend_q <= a_pend_d;
      b_pend_q <= b_pend_d;
      a_pdir_q <= a_pdir_d;
      b_pdir_q <= b_pdir_d;
      edir_q   <= edir_d;
      a_h_q    <= a_h_d;
      a_v_q    <= a_v_d;
      b_h_q    <= b_h_d;
      b_v_q    <= b_v_d;
      a_cd_q   <= a_cd_d;
      b_cd_q   <= b_cd_d;
      a_gnt_q  <= a_gnt_d;
      b_gnt_q  <= b_gnt_d;
      a_blk_q  <= a_blk_d;
      b_blk_q  <= b_blk_d;
    end
  end

  assign a_h       = a_h_q;
  assign a_v       = a_v_q;
  assign b_h       = b_h_q;
  assign b_v       = b_v_q;
  assign a_grant   = a_gnt_q;
  assign b_grant   = b_gnt_q;
  assign a_blocked = a_blk_q;
  assign b_blocked = b_blk_q;

endmodule

// File: tb/tb_move_arbiter.sv
// Directed bench for move_arbiter: a per-cycle vector table
// plus a short collision sequence on a second instance.
module tb_move_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, a_req, b_req;
  logic [1:0] a_dir, b_dir;
  logic [3:0] a_h, a_v, b_h, b_v;
  logic       a_grant, b_grant, a_blocked, b_blocked;

  logic       rst2, a_req2, b_req2;
  logic [1:0] a_dir2, b_dir2;
  logic [3:0] a_h2, a_v2, b_h2, b_v2;
  logic       a_grant2, b_grant2, a_blocked2, b_blocked2;

  move_arbiter #(.COOLDOWN(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_dir(a_dir),
    .b_req(b_req), .b_dir(b_dir),
    .a_h(a_h), .a_v(a_v), .b_h(b_h), .b_v(b_v),
    .a_grant(a_grant), .b_grant(b_grant),
    .a_blocked(a_blocked), .b_blocked(b_blocked)
  );

  move_arbiter #(.COOLDOWN(4), .AINIT_H(8), .AINIT_V(5)) dut2 (
    .clk(clk), .rst(rst2),
    .a_req(a_req2), .a_dir(a_dir2),
    .b_req(b_req2), .b_dir(b_dir2),
    .a_h(a_h2), .a_v(a_v2), .b_h(b_h2), .b_v(b_v2),
    .a_grant(a_grant2), .b_grant(b_grant2),
    .a_blocked(a_blocked2), .b_blocked(b_blocked2)
  );

  typedef struct {
    logic       r;
    logic       ar;
    logic [1:0] ad;
    logic       br;
    logic [1:0] bd;
    logic [19:0] exp;
  } vec_t;

  localparam int NROWS = 39;
  vec_t tbl [NROWS];
  int n_chk = 0;
  int n_fail = 0;

  // pulses packed as {a_grant, b_grant, a_blocked, b_blocked}
  function automatic void set_row(
    input int i, input logic r,
    input logic ar, input logic [1:0] ad,
    input logic br, input logic [1:0] bd,
    input logic [3:0] ah, input logic [3:0] av,
    input logic [3:0] bh, input logic [3:0] bv,
    input logic [3:0] p);
    tbl[i].r   = r;
    tbl[i].ar  = ar;
    tbl[i].ad  = ad;
    tbl[i].br  = br;
    tbl[i].bd  = bd;
    tbl[i].exp = {ah, av, bh, bv, p};
  endfunction

  task automatic check(input string nm,
                       input logic [19:0] act,
                       input logic [19:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < NROWS; i++)
      set_row(i, 0, 0, 0, 0, 0, 0, 0, 9, 5, 4'b0000);
    // single move right, then cooldown expiry
    set_row(3,  0, 1, 2'b11, 0, 0, 0, 0, 9, 5, 4'b0000);
    set_row(6,  0, 0, 0,     0, 0, 1, 0, 9, 5, 4'b1000);
    for (int i = 7; i < 10; i++)
      set_row(i, 0, 0, 0, 0, 0, 1, 0, 9, 5, 4'b0000);
    // up from v=0 is blocked, next request accepted
    set_row(10, 0, 1, 2'b00, 0, 0, 1, 0, 9, 5, 4'b0000);
    set_row(11, 0, 0, 0,     0, 0, 1, 0, 9, 5, 4'b0000);
    set_row(12, 0, 0, 0,     0, 0, 1, 0, 9, 5, 4'b0000);
    set_row(13, 0, 0, 0,     0, 0, 1, 0, 9, 5, 4'b0010);
    set_row(14, 0, 1, 2'b01, 0, 0, 1, 0, 9, 5, 4'b0000);
    set_row(15, 0, 0, 0,     0, 0, 1, 0, 9, 5, 4'b0000);
    set_row(16, 0, 0, 0,     0, 0, 1, 0, 9, 5, 4'b0000);
    set_row(17, 0, 0, 0,     0, 0, 1, 1, 9, 5, 4'b1000);
    set_row(18, 1, 0, 0,     0, 0, 1, 1, 9, 5, 4'b0000);
    // simultaneous requests after reset, A first
    set_row(19, 0, 1, 2'b11, 1, 2'b10, 0, 0, 9, 5, 4'b0000);
    set_row(22, 0, 0, 0,     0, 0, 1, 0, 9, 5, 4'b1000);
    set_row(23, 0, 0, 0,     0, 0, 1, 0, 9, 5, 4'b0000);
    // A request during cooldown dropped
    set_row(24, 0, 1, 2'b11, 0, 0, 1, 0, 8, 5, 4'b0100);
    set_row(25, 0, 0, 0,     0, 0, 1, 0, 8, 5, 4'b0000);
    set_row(26, 0, 1, 2'b11, 0, 0, 1, 0, 8, 5, 4'b0000);
    set_row(27, 0, 0, 0,     0, 0, 1, 0, 8, 5, 4'b0000);
    // reset while A is in evaluation discards the move
    set_row(28, 1, 0, 0,     0, 0, 1, 0, 8, 5, 4'b0000);
    // B dir overwritten while pending; B req in own EVAL dropped
    set_row(30, 0, 1, 2'b11, 1, 2'b00, 0, 0, 9, 5, 4'b0000);
    set_row(31, 0, 0, 0,     1, 2'b10, 0, 0, 9, 5, 4'b0000);
    set_row(33, 0, 0, 0,     0, 0, 1, 0, 9, 5, 4'b1000);
    set_row(34, 0, 0, 0,     1, 2'b00, 1, 0, 9, 5, 4'b0000);
    set_row(35, 0, 0, 0,     0, 0, 1, 0, 8, 5, 4'b0100);
    for (int i = 36; i < NROWS; i++)
      set_row(i, 0, 0, 0, 0, 0, 1, 0, 8, 5, 4'b0000);

    rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
    a_dir = 2'b00; b_dir = 2'b00;
    rst2 = 1'b1; a_req2 = 1'b0; b_req2 = 1'b0;
    a_dir2 = 2'b00; b_dir2 = 2'b00;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NROWS; i++) begin
      @(negedge clk);
      check($sformatf("row%0d", i),
            {a_h, a_v, b_h, b_v,
             a_grant, b_grant, a_blocked, b_blocked},
            tbl[i].exp);
      rst   = tbl[i].r;
      a_req = tbl[i].ar;
      a_dir = tbl[i].ad;
      b_req = tbl[i].br;
      b_dir = tbl[i].bd;
    end

    // A at (8,5) moving right hits B at (9,5); then B left hits A
    for (int c = 0; c < 9; c++) begin
      logic [3:0] p;
      @(negedge clk);
      p = 4'b0000;
      if (c == 4) p = 4'b0010;
      if (c == 8) p = 4'b0001;
      if (c > 0)
        check($sformatf("coll%0d", c),
              {a_h2, a_v2, b_h2, b_v2,
               a_grant2, b_grant2, a_blocked2, b_blocked2},
              {4'd8, 4'd5, 4'd9, 4'd5, p});
      rst2   = 1'b0;
      a_req2 = (c == 1);
      a_dir2 = 2'b11;
      b_req2 = (c == 5);
      b_dir2 = 2'b10;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
